// File: rtl/perceptron_weight_update_pkg.sv
// Shared types, Q32.32 constants and fixed-point helpers
// for the perceptron weight-update block.
package perceptron_weight_update_pkg;

  typedef logic signed [63:0] sfp_t;

  localparam sfp_t ONE     = 64'sh0000_0001_0000_0000;
  localparam sfp_t SFP_MAX = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam sfp_t SFP_MIN = 64'sh8000_0000_0000_0000;

  typedef enum logic [1:0] {
    STEP,
    SIGMOID,
    TANH,
    RELU
  } act_func_t;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    SCALE,
    STREAM,
    FLUSH
  } upd_state_t;

  function automatic sfp_t sfp_mul(input sfp_t a, input sfp_t b);
    logic signed [127:0] p;
    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
    return p[95:32];
  endfunction

  function automatic sfp_t sfp_add(input sfp_t a, input sfp_t b);
    return a + b;
  endfunction

  function automatic sfp_t sfp_add_sat(input sfp_t a, input sfp_t b);
    sfp_t s;
    s = a + b;
    if (a[63] == b[63] && s[63] != a[63])
      s = a[63] ? SFP_MIN : SFP_MAX;
    return s;
  endfunction

endpackage

// File: rtl/perceptron_weight_update_if.sv
// Control, parameter and weight-stream signals of the
// weight-update block; slave is the block side.
interface perceptron_weight_update_if #(
  parameter int N_INPUTS = 4
);
  localparam int IW = $clog2(N_INPUTS + 1);

  logic          start;
  logic          ready;
  logic [63:0]   y;
  logic [63:0]   target;
  logic [63:0]   lr;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   x_in;
  logic [63:0]   w_in;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   w_out;
  logic [IW-1:0] idx_out;
  logic          done;

  modport master (
    output start, y, target, lr,
    output in_valid, x_in, w_in, out_ready,
    input  ready, in_ready, out_valid,
    input  w_out, idx_out, done
  );

  modport slave (
    input  start, y, target, lr,
    input  in_valid, x_in, w_in, out_ready,
    output ready, in_ready, out_valid,
    output w_out, idx_out, done
  );
endinterface

// File: rtl/sfp_activation_deriv.sv
// Combinational activation derivative f'(y) expressed
// in terms of the activation output y.
module sfp_activation_deriv
  import perceptron_weight_update_pkg::*;
#(
  parameter act_func_t ACT = SIGMOID
) (
  input  sfp_t y,
  output sfp_t deriv
);

  always_comb begin
    deriv = ONE;
    unique case (ACT)
      STEP:    deriv = ONE;
      SIGMOID: deriv = sfp_mul(y, ONE - y);
      TANH:    deriv = ONE - sfp_mul(y, y);
      RELU:    deriv = (y > 0) ? ONE : '0;
    endcase
  end

endmodule

// File: rtl/perceptron_weight_update.sv
// delta = lr*(target-y)*f'(y), then w_new = w + delta*x per beat.
// PERCEPTRON_UPDATE_SAT_EN: saturating final add instead of wrap.
module perceptron_weight_update
  import perceptron_weight_update_pkg::*;
#(
  parameter int        N_INPUTS = 4,
  parameter act_func_t ACT      = SIGMOID
) (
  input logic clk,
  input logic rst_n,
  perceptron_weight_update_if.slave bus
);

  localparam int            IW   = $clog2(N_INPUTS + 1);
  localparam logic [IW-1:0] LAST = IW'(N_INPUTS);

  upd_state_t    state, state_nx;
  sfp_t          y_q, tgt_q, lr_q;
  sfp_t          err_q, deriv_q, delta_q;
  sfp_t          deriv, prod, sum, w_q;
  logic [IW-1:0] cnt, idx_q;
  logic          ov_q, done_q;
  logic          accept, drain, last;

  sfp_activation_deriv #(.ACT(ACT)) u_deriv (
    .y     (y_q),
    .deriv (deriv)
  );

  assign bus.ready     = (state == IDLE);
  assign bus.in_ready  = (state == STREAM) &&
                         (!ov_q || bus.out_ready);
  assign bus.out_valid = ov_q;
  assign bus.w_out     = w_q;
  assign bus.idx_out   = idx_q;
  assign bus.done      = done_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = ov_q && bus.out_ready;
  assign last   = (cnt == LAST);

  // bias beat ignores x_in and uses ONE
  assign prod = sfp_mul(delta_q, last ? ONE : sfp_t'(bus.x_in));
`ifdef PERCEPTRON_UPDATE_SAT_EN
  assign sum  = sfp_add_sat(bus.w_in, prod);
`else
  assign sum  = sfp_add(bus.w_in, prod);
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = ERR;
      ERR:     state_nx = SCALE;
      SCALE:   state_nx = STREAM;
      STREAM:  if (accept && last) state_nx = FLUSH;
      FLUSH:   if (drain) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      tgt_q   <= '0;
      lr_q    <= '0;
      err_q   <= '0;
      deriv_q <= '0;
      delta_q <= '0;
      cnt     <= '0;
      ov_q    <= 1'b0;
      w_q     <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == FLUSH) && drain;
      if (state == IDLE && bus.start) begin
        y_q   <= bus.y;
        tgt_q <= bus.target;
        lr_q  <= bus.lr;
        cnt   <= '0;
      end
      if (state == ERR) begin
        err_q   <= tgt_q - y_q;
        deriv_q <= deriv;
      end
      if (state == SCALE)
        delta_q <= sfp_mul(lr_q, sfp_mul(err_q, deriv_q));
      // a new accept overwrites the slot being drained
      if (accept) begin
        ov_q  <= 1'b1;
        w_q   <= sum;
        idx_q <= cnt;
        cnt   <= last ? '0 : cnt + 1'b1;
      end else if (drain) begin
        ov_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_weight_update.sv
// Scoreboard bench: Sigmoid(N=2), Tanh(N=4), ReLU(N=4)
// instances share stimulus; sel picks the active one.
module tb_perceptron_weight_update;
  import perceptron_weight_update_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_c = 1'b0;
  logic        iv_c = 1'b0;
  logic        ordy_c = 1'b1;
  logic [63:0] y_c = '0, tgt_c = '0, lr_c = '0;
  logic [63:0] x_c = '0, w_c = '0;
  int          sel = 1;
  logic        sb_on = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic [63:0] xs [5];
  logic [63:0] ws [5];
  logic [63:0] es [5];

  typedef struct {
    logic [2:0]  idx;
    logic [63:0] w;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  perceptron_weight_update_if #(.N_INPUTS(2)) if_s ();
  perceptron_weight_update_if #(.N_INPUTS(4)) if_t ();
  perceptron_weight_update_if #(.N_INPUTS(4)) if_r ();

  assign if_s.start     = start_c && (sel == 0);
  assign if_s.in_valid  = iv_c && (sel == 0);
  assign if_s.y         = y_c;
  assign if_s.target    = tgt_c;
  assign if_s.lr        = lr_c;
  assign if_s.x_in      = x_c;
  assign if_s.w_in      = w_c;
  assign if_s.out_ready = ordy_c;

  assign if_t.start     = start_c && (sel == 1);
  assign if_t.in_valid  = iv_c && (sel == 1);
  assign if_t.y         = y_c;
  assign if_t.target    = tgt_c;
  assign if_t.lr        = lr_c;
  assign if_t.x_in      = x_c;
  assign if_t.w_in      = w_c;
  assign if_t.out_ready = ordy_c;

  assign if_r.start     = start_c && (sel == 2);
  assign if_r.in_valid  = iv_c && (sel == 2);
  assign if_r.y         = y_c;
  assign if_r.target    = tgt_c;
  assign if_r.lr        = lr_c;
  assign if_r.x_in      = x_c;
  assign if_r.w_in      = w_c;
  assign if_r.out_ready = ordy_c;

  perceptron_weight_update #(.N_INPUTS(2), .ACT(SIGMOID)) u_sig (
    .clk(clk), .rst_n(rst_n), .bus(if_s));
  perceptron_weight_update #(.N_INPUTS(4), .ACT(TANH)) u_tanh (
    .clk(clk), .rst_n(rst_n), .bus(if_t));
  perceptron_weight_update #(.N_INPUTS(4), .ACT(RELU)) u_relu (
    .clk(clk), .rst_n(rst_n), .bus(if_r));

  logic        ready_m, in_ready_m, ov_m, done_m;
  logic [63:0] w_out_m;
  logic [2:0]  idx_m;

  always_comb begin
    ready_m    = if_t.ready;
    in_ready_m = if_t.in_ready;
    ov_m       = if_t.out_valid;
    done_m     = if_t.done;
    w_out_m    = if_t.w_out;
    idx_m      = if_t.idx_out;
    if (sel == 0) begin
      ready_m    = if_s.ready;
      in_ready_m = if_s.in_ready;
      ov_m       = if_s.out_valid;
      done_m     = if_s.done;
      w_out_m    = if_s.w_out;
      idx_m      = {1'b0, if_s.idx_out};
    end else if (sel == 2) begin
      ready_m    = if_r.ready;
      in_ready_m = if_r.in_ready;
      ov_m       = if_r.out_valid;
      done_m     = if_r.done;
      w_out_m    = if_r.w_out;
      idx_m      = if_r.idx_out;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // outputs compared at negedge; a transfer happens at the next posedge
  always @(negedge clk) begin
    if (rst_n && sb_on && ov_m) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else if (ordy_c) begin
        mon_e = exp_q.pop_front();
        check("w_out", w_out_m, mon_e.w);
        check("idx_out", 64'(idx_m), 64'(mon_e.idx));
      end else begin
        check("stall_w", w_out_m, exp_q[0].w);
        check("stall_idx", 64'(idx_m), 64'(exp_q[0].idx));
        check("stall_in_ready", 64'(in_ready_m), 64'd0);
      end
    end
  end

  task automatic run_update(input int s, input logic [63:0] y,
                            input logic [63:0] t,
                            input logic [63:0] l, input int n);
    int lat;
    int g;
    sel = s;
    y_c = y;
    tgt_c = t;
    lr_c = l;
    start_c = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      if (in_ready_m) break;
      lat++;
      @(posedge clk); #1;
      start_c = 1'b0;
    end
    start_c = 1'b0;
    check("in_ready_lat", 64'(lat), 64'd3);
    @(posedge clk); #1;
    for (int k = 0; k <= n; k++) begin
      iv_c = 1'b1;
      x_c = xs[k];
      w_c = ws[k];
      g = 0;
      while (g < 100) begin
        @(negedge clk);
        if (in_ready_m) break;
        g++;
      end
      if (g >= 100) begin
        check("beat_timeout", 64'(g), 64'd0);
        break;
      end
      exp_q.push_back('{idx: 3'(k), w: es[k]});
      @(posedge clk); #1;
    end
    iv_c = 1'b0;
    g = 0;
    while (g < 100) begin
      @(negedge clk);
      if (done_m) break;
      g++;
    end
    check("done", 64'(done_m), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("done_pulse", 64'(done_m), 64'd0);
    check("ready_after", 64'(ready_m), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready_m), 64'd1);
    check("rst_in_ready", 64'(in_ready_m), 64'd0);
    check("rst_out_valid", 64'(ov_m), 64'd0);
    check("rst_w_out", w_out_m, 64'd0);
    check("rst_idx", 64'(idx_m), 64'd0);
    check("rst_done", 64'(done_m), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // sigmoid, N=2: delta = 0.125; bias x_in is junk
    xs = '{ONE, 64'h2_0000_0000, 64'hDEAD_BEEF, 0, 0};
    ws = '{0, 0, 0, 0, 0};
    es = '{64'h2000_0000, 64'h4000_0000, 64'h2000_0000, 0, 0};
    run_update(0, 64'h8000_0000, ONE, ONE, 2);

    // tanh y=0, lr=0.5: delta = 0.5
    xs = '{ONE, ONE, ONE, ONE, 64'hDEAD_BEEF};
    ws = '{ONE, ONE, ONE, ONE, ONE};
    es = '{64'h1_8000_0000, 64'h1_8000_0000, 64'h1_8000_0000,
           64'h1_8000_0000, 64'h1_8000_0000};
    run_update(1, 64'h0, ONE, 64'h8000_0000, 4);

    // relu y=0: delta = 0, weights pass through
    xs = '{ONE, 64'h2_0000_0000, 64'hFFFF_FFFF_0000_0000,
           64'h1234, 64'h0};
    ws = '{64'h3_1234_5678, 64'hFFFF_FFF0_0000_0001,
           64'h7, 64'h8000_0000_0000_0000, 64'h9_0000_0000};
    es = ws;
    run_update(2, 64'h0, ONE, ONE, 4);

    // tanh delta=0.5 with a 5-cycle out_ready stall mid-stream
    xs = '{ONE, 64'h2_0000_0000, 64'hFFFF_FFFF_0000_0000,
           64'h4000_0000, 64'h5555};
    ws = '{0, ONE, ONE, 0, ONE};
    es = '{64'h8000_0000, 64'h2_0000_0000, 64'h8000_0000,
           64'h2000_0000, 64'h1_8000_0000};
    fork
      begin
        repeat (5) @(posedge clk);
        #1 ordy_c = 1'b0;
        repeat (5) @(posedge clk);
        #1 ordy_c = 1'b1;
      end
    join_none
    run_update(1, 64'h0, ONE, 64'h8000_0000, 4);

    // tanh delta=ONE: positive overflow on beat 0
    xs = '{ONE, 0, 0, 0, 64'h77};
    ws = '{64'h7FFF_FFFF_0000_0000, 64'h1, 64'h2, 64'h3, 64'h10};
`ifdef PERCEPTRON_UPDATE_SAT_EN
    es = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h2, 64'h3,
           64'h1_0000_0010};
`else
    es = '{64'h8000_0000_0000_0000, 64'h1, 64'h2, 64'h3,
           64'h1_0000_0010};
`endif
    run_update(1, 64'h0, ONE, ONE, 4);

    // reset while streaming, then a clean update
    sel = 1;
    sb_on = 1'b0;
    y_c = 0;
    tgt_c = ONE;
    lr_c = ONE;
    start_c = 1'b1;
    @(posedge clk); #1;
    start_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    iv_c = 1'b1;
    x_c = ONE;
    w_c = 0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_out_valid", 64'(ov_m), 64'd1);
    rst_n = 1'b0;
    iv_c = 1'b0;
    #1;
    check("mid_rst_ready", 64'(ready_m), 64'd1);
    check("mid_rst_in_ready", 64'(in_ready_m), 64'd0);
    check("mid_rst_out_valid", 64'(ov_m), 64'd0);
    check("mid_rst_w_out", w_out_m, 64'd0);
    check("mid_rst_idx", 64'(idx_m), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    sb_on = 1'b1;
    @(posedge clk); #1;
    // tanh y=0.25: delta = 0.75 * 0.9375 = 0xB400_0000
    xs = '{ONE, 0, 0, 0, 0};
    ws = '{0, 0, 0, 0, 0};
    es = '{64'hB400_0000, 0, 0, 0, 64'hB400_0000};
    run_update(1, 64'h4000_0000, ONE, ONE, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
